sram_bank: RTL and testbench

SRAM_BANK -- requirements
Module: sram_bank

---
 rtl/sram_bank.sv | 122 ++++++++++++
 tb/tb_sram_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sram_bank.sv
// Single-port word SRAM bank with byte-enable writes, registered reads and a
// valid/ready response. Optional power-on clear: SRAM_BANK_INIT_CLEAR_EN.
package core_cfg;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int XLEN           = 64;
endpackage

// state   | meaning
// INIT    | clearing array one word per cycle, requests blocked
// IDLE    | serving requests
module sram_bank #(
    parameter int ADDR_WIDTH = core_cfg::REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = core_cfg::XLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    generate
        if (DATA_WIDTH % 8 != 0) begin : g_width_check
            $error("sram_bank: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_idle;
    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_accept;

`ifdef SRAM_BANK_INIT_CLEAR_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign in_idle   = (state == ST_IDLE);
    assign init_we   = (state == ST_INIT);
    assign init_busy = rst_n && (state == ST_INIT);
`else
    // Without the clear there is no state; ready is only masked while in reset.
    assign in_idle   = rst_n;
    assign init_we   = 1'b0;
    assign init_cnt  = '0;
    assign init_busy = 1'b0;
`endif

    assign req_ready = in_idle && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;
    assign wr_accept = accept && req_we;

    // Array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (rd_accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem[req_addr];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_bank.sv
// Self-checking bench for sram_bank (ADDR_WIDTH=5, DATA_WIDTH=64); adapts to
// SRAM_BANK_INIT_CLEAR_EN being defined or not.
module tb_sram_bank;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        init_busy;

    sram_bank #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: word array, queue of responses owed, last data delivered.
    logic [63:0] mdl [32];
    logic [63:0] q [$];
    logic [63:0] last_rd;
    int          init_left;
    int          tests;
    int          fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic step(input logic v, input logic we, input logic [4:0] a,
                        input logic [63:0] wd, input logic [7:0] be, input logic rr);
        logic exp_ready;
        logic acc;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        rsp_ready = rr;
        #1;
        exp_ready = (init_left == 0) && (q.size() == 0 || rr);
        chk("req_ready", {63'b0, req_ready}, {63'b0, exp_ready});
        chk("init_busy", {63'b0, init_busy}, {63'b0, init_left != 0});
        acc = v && exp_ready;
        @(posedge clk);
        if (init_left > 0) init_left--;
        if (q.size() != 0 && rr) void'(q.pop_front());
        if (acc && we) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) mdl[a][8*b +: 8] = wd[8*b +: 8];
        end else if (acc) begin
            q.push_back(mdl[a]);
            last_rd = mdl[a];
        end
        #1;
        chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, q.size() != 0});
        chk("rsp_rdata", rsp_rdata, (q.size() != 0) ? q[0] : last_rd);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_req_ready", {63'b0, req_ready}, 64'd0);
        q.delete();
        last_rd = 64'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef SRAM_BANK_INIT_CLEAR_EN
        init_left = 32;
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
`else
        init_left = 0;
`endif
    endtask

    task automatic rand_phase(input int n);
        logic        v, we, rr;
        logic [4:0]  a;
        logic [63:0] wd;
        logic [7:0]  be;
        for (int i = 0; i < n; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            be = 8'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            step(v, we, a, wd, be, rr);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        init_left = 0;
        last_rd   = 64'd0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
        @(posedge clk);
        #1;
        do_reset();

`ifdef SRAM_BANK_INIT_CLEAR_EN
        // Requests offered during the clear must be ignored.
        repeat (32) step(1'b1, 1'b0, 5'd7, 64'd0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 5'd7, 64'd0, 8'h00, 1'b1);
        chk("init_rd7_zero", rsp_rdata, 64'd0);
        step(1'b0, 1'b0, 5'd0, 64'd0, 8'h00, 1'b1);
`else
        for (int a = 0; a < 32; a++)
            step(1'b1, 1'b1, 5'(a), {$urandom, $urandom}, 8'hFF, 1'b1);
`endif

        step(1'b1, 1'b1, 5'd3, 64'h1122334455667788, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1);
        step(1'b1, 1'b0, 5'd3, 64'd0, 8'h00, 1'b1);
        chk("raw_merge", rsp_rdata, 64'h11223344AAAAAAAA);
        step(1'b1, 1'b1, 5'd3, 64'hDEADBEEFDEADBEEF, 8'h00, 1'b1);
        step(1'b1, 1'b0, 5'd3, 64'd0, 8'h00, 1'b1);
        chk("be0_noop", rsp_rdata, 64'h11223344AAAAAAAA);
        step(1'b0, 1'b0, 5'd0, 64'd0, 8'h00, 1'b1);

        for (int a = 0; a < 3; a++)
            step(1'b1, 1'b1, 5'(a), 64'h100 + 64'(a), 8'hFF, 1'b1);
        for (int a = 0; a < 3; a++) begin
            step(1'b1, 1'b0, 5'(a), 64'd0, 8'h00, 1'b1);
            chk("b2b_data", rsp_rdata, 64'h100 + 64'(a));
        end
        step(1'b0, 1'b0, 5'd0, 64'd0, 8'h00, 1'b1);

        step(1'b1, 1'b1, 5'd5, 64'h55, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 5'd5, 64'd0, 8'h00, 1'b1);
        repeat (4) begin
            step(1'b1, 1'b0, 5'd9, 64'd0, 8'h00, 1'b0);
            chk("stall_hold", rsp_rdata, 64'h55);
        end
        step(1'b1, 1'b0, 5'd9, 64'd0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 5'd0, 64'd0, 8'h00, 1'b1);

        rand_phase(400);

        // Reset while a response is stalled.
        step(1'b0, 1'b0, 5'd0, 64'd0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 5'd5, 64'd0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 5'd0, 64'd0, 8'h00, 1'b0);
        do_reset();

`ifdef SRAM_BANK_INIT_CLEAR_EN
        repeat (10) step(1'b0, 1'b0, 5'd0, 64'd0, 8'h00, 1'b1);
        do_reset();
        repeat (32) step(1'b1, 1'b0, 5'd2, 64'd0, 8'h00, 1'b1);
`endif
        rand_phase(200);
        step(1'b0, 1'b0, 5'd0, 64'd0, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
